// File: rtl/nuc_pkg.sv
// Shared definitions for the nucleotide frequency estimator and its sampler
// neighbours: symbol encodings, widths, the estimator state enum and the
// count-to-numerator scaling helper.
package nuc_pkg;

    localparam int CNT_W             = 12;              // counters and total; 4095 must fit
    localparam int PROB_W            = 10;              // sampler probability width
    localparam int PROB_MAX          = 1023;
    localparam int SAMPLER_SUM_LIMIT = 4093;            // sampler rejects prob sums above this
    localparam int NUM_W             = CNT_W + PROB_W;  // exact width of cnt*1023

    localparam logic [1:0] NUC_A = 2'b00;
    localparam logic [1:0] NUC_C = 2'b01;
    localparam logic [1:0] NUC_G = 2'b10;
    localparam logic [1:0] NUC_T = 2'b11;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_HOLD   = 2'd2
    } est_state_e;

    // cnt*1023 computed as cnt*1024 - cnt, so no multiplier is needed.
    function automatic logic [NUM_W-1:0] scale_count(input logic [CNT_W-1:0] cnt);
        return ({{PROB_W{1'b0}}, cnt} << PROB_W) - {{PROB_W{1'b0}}, cnt};
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               begin a division (honoured only when not busy)
//   dividend, divisor   operands, sampled on the start cycle
//   busy                division in progress
//   done                one-cycle pulse after the last quotient bit
//   quotient            low QUO_W bits of the quotient, valid while done
// The first quotient bit is produced on the same edge that samples start, so a
// division takes exactly DVD_W edges and a new start may be issued during done.
module seq_divider #(
    parameter int DVD_W = 22,
    parameter int DVS_W = 12,
    parameter int QUO_W = DVD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int SC_W = $clog2(DVD_W);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVD_W-1:0] quo_q, quo_d;   // remaining dividend bits shift out the top, quotient bits in at the bottom
    logic [SC_W-1:0]  step_q, step_d; // steps left after the next one
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fire;
    logic [DVS_W-1:0] rem_in;
    logic [DVS_W-1:0] dvs_in;
    logic [DVD_W-1:0] quo_in;
    logic [DVS_W:0]   trial;
    logic             fits;

    always_comb begin
        fire   = start && !busy_q;
        rem_in = fire ? '0       : rem_q;
        quo_in = fire ? dividend : quo_q;
        dvs_in = fire ? divisor  : dvs_q;
        trial  = {rem_in, quo_in[DVD_W-1]};
        fits   = (trial >= {1'b0, dvs_in});

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (fire || busy_q) begin
            // The partial remainder is always below the divisor, so it fits DVS_W bits.
            rem_d = fits ? DVS_W'(trial - {1'b0, dvs_in}) : trial[DVS_W-1:0];
            quo_d = {quo_in[DVD_W-2:0], fits};
            dvs_d = dvs_in;
            if (fire) begin
                busy_d = 1'b1;
                step_d = SC_W'(DVD_W - 2);
            end else if (step_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                step_d = step_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            step_q <= step_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q[QUO_W-1:0];

endmodule

// File: rtl/nuc_freq_estimator.sv
// Counts A/C/G/T symbols over a window and reports each as floor(cnt*1023/total),
// ready to drive a sampler's prob_A..prob_T inputs.
// Ports:
//   clk, reset                     clock, async active-high reset
//   in_valid/in_nuc/in_last        symbol stream; in_last closes the window early
//   in_ready                       symbol accepted this cycle (registered)
//   out_valid/out_ready            result handshake
//   prob_A..prob_T, out_total      frequencies and sample count of the closed window
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCUM  | accepting symbols, counting per symbol and in total
// ST_DIVIDE | dividing A, C, G, T in turn through one shared divider
// ST_HOLD   | result presented, waiting for out_ready
module nuc_freq_estimator
    import nuc_pkg::*;
#(
    parameter int WINDOW = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_nuc,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROB_W-1:0] prob_A,
    output logic [PROB_W-1:0] prob_C,
    output logic [PROB_W-1:0] prob_G,
    output logic [PROB_W-1:0] prob_T,
    output logic [CNT_W-1:0]  out_total
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    est_state_e                  state_q, state_d;
    logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]            total_q, total_d;
    logic [CNT_W-1:0]            out_total_q, out_total_d;
    logic [3:0][PROB_W-1:0]      prob_q, prob_d;
    logic [1:0]                  sym_q, sym_d;
    logic                        in_ready_q, in_ready_d;
    logic                        start_q, start_d;

    logic                        accept;
    logic                        closing;
    logic                        div_start;
    logic                        div_busy;
    logic                        div_done;
    logic [1:0]                  div_sym;
    logic [NUM_W-1:0]            div_num;
    logic [PROB_W-1:0]           div_quot;

    assign accept  = (state_q == ST_ACCUM) && in_valid && in_ready_q;
    assign closing = accept && (in_last || (total_q == WIN_LAST));

    // The first division is kicked by start_q; each later one starts in the
    // done cycle of the previous symbol so the four divisions run back to back.
    assign div_start = !div_busy &&
                       (start_q || ((state_q == ST_DIVIDE) && div_done && (sym_q != 2'd3)));
    assign div_sym   = start_q ? 2'd0 : sym_q + 2'd1;
    assign div_num   = scale_count(cnt_q[div_sym]);

    seq_divider #(
        .DVD_W (NUM_W),
        .DVS_W (CNT_W),
        .QUO_W (PROB_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (total_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        out_total_d = out_total_q;
        prob_d      = prob_q;
        sym_d       = sym_q;
        in_ready_d  = in_ready_q;
        start_d     = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    cnt_d[in_nuc] = cnt_q[in_nuc] + 1'b1;
                    total_d       = total_q + 1'b1;
                end
                if (closing) begin
                    state_d    = ST_DIVIDE;
                    in_ready_d = 1'b0;
                    start_d    = 1'b1;
                    sym_d      = 2'd0;
                end
            end
            ST_DIVIDE: begin
                in_ready_d = 1'b0;
                if (div_done) begin
                    prob_d[sym_q] = div_quot;
                    if (sym_q == 2'd3) begin
                        state_d     = ST_HOLD;
                        out_total_d = total_q;
                    end else begin
                        sym_d = sym_q + 2'd1;
                    end
                end
            end
            ST_HOLD: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    state_d    = ST_ACCUM;
                    cnt_d      = '0;
                    total_d    = '0;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_ACCUM;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            total_q     <= '0;
            out_total_q <= '0;
            prob_q      <= '0;
            sym_q       <= 2'd0;
            in_ready_q  <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            out_total_q <= out_total_d;
            prob_q      <= prob_d;
            sym_q       <= sym_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_HOLD);
    assign prob_A    = prob_q[0];
    assign prob_C    = prob_q[1];
    assign prob_G    = prob_q[2];
    assign prob_T    = prob_q[3];
    assign out_total = out_total_q;

endmodule

// File: tb/tb_nuc_freq_estimator.sv
module tb_nuc_freq_estimator;
    import nuc_pkg::*;

    localparam int WINDOW  = 1024;
    localparam int LATENCY = 89;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [1:0]        in_nuc = 2'b00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [PROB_W-1:0] prob_A, prob_C, prob_G, prob_T;
    logic [CNT_W-1:0]  out_total;

    nuc_freq_estimator #(.WINDOW(WINDOW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_nuc    (in_nuc),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prob_A    (prob_A),
        .prob_C    (prob_C),
        .prob_G    (prob_G),
        .prob_T    (prob_T),
        .out_total (out_total)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t_last = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 collecting, 1 computing, 2 presenting.
    int m_phase = 0;
    int m_ready = 0;
    int m_left  = 0;
    int m_cnt [4];
    int m_total = 0;
    int e_prob [4];
    int e_total = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_ready = 0; m_total = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_ready == 1 && in_valid) begin
                        m_cnt[in_nuc]++;
                        m_total++;
                        if (in_last || m_total == WINDOW) begin
                            for (int i = 0; i < 4; i++) e_prob[i] = (m_cnt[i] * 1023) / m_total;
                            e_total = m_total;
                            m_phase = 1; m_left = LATENCY; m_ready = 0;
                        end else m_ready = 1;
                    end else m_ready = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: begin
                    if (out_ready) begin
                        m_phase = 0; m_ready = 1; m_total = 0;
                        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_prob_sum", prob_A + prob_C + prob_G + prob_T, 0);
            check("rst_out_total", out_total, 0);
        end else begin
            check("in_ready", in_ready, m_ready);
            check("out_valid", out_valid, (m_phase == 2) ? 1 : 0);
            if (m_phase == 2) begin
                check("prob_A", prob_A, e_prob[0]);
                check("prob_C", prob_C, e_prob[1]);
                check("prob_G", prob_G, e_prob[2]);
                check("prob_T", prob_T, e_prob[3]);
                check("out_total", out_total, e_total);
                check("prob_sum_le_max",
                      ((prob_A + prob_C + prob_G + prob_T) <= PROB_MAX) ? 1 : 0, 1);
            end
        end
    end

    task automatic send(input logic [1:0] n, input logic last);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_nuc = n; in_last = last;
        @(negedge clk);
        while (!in_ready && guard < 200) begin guard++; @(negedge clk); end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        t_last = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input bit chk_lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 300) begin guard++; @(negedge clk); end
        if (!out_valid) check({tag, "_valid_timeout"}, out_valid, 1);
        else if (chk_lat) check({tag, "_latency"}, cyc - t_last, LATENCY);
    endtask

    task automatic expect_lit(input string tag, input int a, input int c, input int g,
                              input int t, input int tot);
        check({tag, "_A"}, prob_A, a);
        check({tag, "_C"}, prob_C, c);
        check({tag, "_G"}, prob_G, g);
        check({tag, "_T"}, prob_T, t);
        check({tag, "_total"}, out_total, tot);
    endtask

    task automatic finish_hs();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 check("post_release_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("first_edge_in_ready", in_ready, 1);

        // all A, automatic close at WINDOW
        for (int i = 0; i < WINDOW; i++) send(NUC_A, 1'b0);
        wait_valid("allA", 1'b1);
        expect_lit("allA", 1023, 0, 0, 0, 1024);
        finish_hs();

        // round robin
        for (int i = 0; i < WINDOW; i++) send(2'(i % 4), 1'b0);
        wait_valid("rr", 1'b1);
        expect_lit("rr", 255, 255, 255, 0 + 255, 1024);
        finish_hs();

        // A, C, G with early close
        send(NUC_A, 1'b0); send(NUC_C, 1'b0); send(NUC_G, 1'b1);
        wait_valid("acg", 1'b1);
        expect_lit("acg", 341, 341, 341, 0, 3);
        finish_hs();

        // 700 A / 200 C / 100 G
        for (int i = 0; i < 1000; i++)
            send((i < 700) ? NUC_A : (i < 900) ? NUC_C : NUC_G, (i == 999));
        wait_valid("mix", 1'b1);
        expect_lit("mix", 716, 204, 102, 0, 1000);
        finish_hs();

        // backpressure with in_valid held during HOLD
        out_ready = 1'b0;
        send(NUC_G, 1'b0); send(NUC_G, 1'b0); send(NUC_C, 1'b1);
        wait_valid("bp", 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_nuc = 2'(i % 4); in_last = (i % 2 == 1);
            @(negedge clk);
            expect_lit("bp_hold", 0, 341, 682, 0, 3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_after_hs", out_valid, 0);
        check("bp_ready_after_hs", in_ready, 1);
        send(NUC_C, 1'b1);
        wait_valid("bp_next", 1'b1);
        expect_lit("bp_next", 0, 1023, 0, 0, 1);
        finish_hs();

        // reset during DIVIDE
        send(NUC_A, 1'b0); send(NUC_C, 1'b1);
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 0);
        expect_lit("rst_mid", 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1 check("rst_rel_ready", in_ready, 0);
        @(posedge clk); #1;
        check("rst_rel_ready_edge", in_ready, 1);
        repeat (100) @(posedge clk);
        #1 check("rst_no_stale_valid", out_valid, 0);
        send(NUC_T, 1'b0); send(NUC_T, 1'b0); send(NUC_T, 1'b1);
        wait_valid("rstT", 1'b1);
        expect_lit("rstT", 0, 0, 0, 1023, 3);
        check("rstT_sum_within_sampler_limit",
              ((prob_A + prob_C + prob_G + prob_T) <= SAMPLER_SUM_LIMIT) ? 1 : 0, 1);
        finish_hs();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
